// File: rtl/rv32i_pkg.sv
// Shared rv32i types and constants.
//   XLEN/ILEN          : address and instruction widths
//   addr_t / word_t    : address and instruction word types
//   INSTR_NOP          : canonical addi x0,x0,0
//   RESET_PC_DEFAULT   : default fetch address after reset
//   align_word()       : clears the byte-offset bits of an address
package rv32i_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   typedef logic [XLEN-1:0] addr_t;
   typedef logic [ILEN-1:0] word_t;

   localparam word_t INSTR_NOP        = 32'h0000_0013;
   localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

   function automatic addr_t align_word(input addr_t a);
      return a & ~addr_t'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous in-order FIFO; flush has priority over push/pop.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : empty the FIFO this edge
//   push, wdata   : write request and data (ignored when full without a pop)
//   pop           : read request (ignored when empty)
//   rdata         : head entry
//   count         : number of entries held
//   empty, full   : status flags
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Status and qualified requests; a push into a full FIFO is legal only with a pop.
   always_comb begin
      empty   = (count == '0);
      full    = (count == CW'(DEPTH));
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      rdata   = mem[rd_ptr];
   end

   // Storage array, no reset needed: contents are only visible through count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rv32i instruction fetch front-end.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   imem_req_o/addr_o         : word fetch request and address
//   imem_gnt_i                : request accepted
//   imem_rvalid_i/rdata_i     : in-order response word
//   redirect_i/redirect_pc_i  : flush and restart fetch at a new PC
//   instr_valid_o/instr_o/instr_pc_o, instr_ready_i : decoder handshake
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter addr_t       RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic  clk_i,
   input  logic  rst_i,
   output logic  imem_req_o,
   output addr_t imem_addr_o,
   input  logic  imem_gnt_i,
   input  logic  imem_rvalid_i,
   input  word_t imem_rdata_i,
   input  logic  redirect_i,
   input  addr_t redirect_pc_i,
   output logic  instr_valid_o,
   output word_t instr_o,
   output addr_t instr_pc_o,
   input  logic  instr_ready_i
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   addr_t         fetch_pc;
   addr_t         deliver_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] fifo_count;
   logic          init_hold;
   logic          credit;
   logic          grant;
   logic          rsp;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic          fifo_full;

   assign imem_addr_o   = fetch_pc;
   assign instr_pc_o    = deliver_pc;
   assign instr_valid_o = !fifo_empty;

   // Request credit and per-cycle events. A response with nothing outstanding is ignored.
   always_comb begin
      credit     = ((CW+1)'(outstanding) + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH);
      imem_req_o = !rst_i && !init_hold && !redirect_i && credit;
      grant      = imem_req_o && imem_gnt_i;
      rsp        = imem_rvalid_i && (outstanding != '0);
      push       = rsp && (discard == '0) && !redirect_i && !fifo_full;
      pop        = instr_valid_o && instr_ready_i && !redirect_i;
   end

   // PCs and in-flight bookkeeping; redirect overrides grant, response and pop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc    <= RESET_PC;
         deliver_pc  <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         init_hold   <= 1'b1;
      end else begin
         init_hold   <= 1'b0;
         outstanding <= outstanding + CW'(grant) - CW'(rsp);
         if (redirect_i) begin
            fetch_pc   <= align_word(redirect_pc_i);
            deliver_pc <= align_word(redirect_pc_i);
            // Everything still in flight after this edge belongs to the old stream.
            discard    <= outstanding - CW'(rsp);
         end else begin
            if (grant) begin
               fetch_pc <= fetch_pc + addr_t'(4);
            end
            if (pop) begin
               deliver_pc <= deliver_pc + addr_t'(4);
            end
            if (rsp && (discard != '0)) begin
               discard <= discard - CW'(1);
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ILEN)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .flush (redirect_i),
      .push  (push),
      .pop   (pop),
      .wdata (imem_rdata_i),
      .rdata (instr_o),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with a behavioural memory model.
// Fetch streams are tracked by epoch: every reset/redirect starts a new epoch at a
// new PC, and only responses to requests granted in the current epoch may reach
// the decoder, in address order, carrying the memory word for their PC.
module tb_fetch_unit;
   import rv32i_pkg::*;

   localparam int unsigned DEPTH  = 4;
   localparam addr_t       RST_PC = 32'hFFFF_FFF8;

   logic  clk = 1'b0;
   logic  rst_i = 1'b1;
   logic  imem_req_o;
   addr_t imem_addr_o;
   logic  imem_gnt_i = 1'b0;
   logic  imem_rvalid_i = 1'b0;
   word_t imem_rdata_i = '0;
   logic  redirect_i = 1'b0;
   addr_t redirect_pc_i = '0;
   logic  instr_valid_o;
   word_t instr_o;
   addr_t instr_pc_o;
   logic  instr_ready_i = 1'b0;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) u_dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i)
   );

   typedef struct {
      addr_t dut_addr;
      addr_t exp_pc;
      int    ep;
      int    due;
   } mem_req_t;

   typedef struct {
      addr_t pc;
      word_t instr;
   } exp_t;

   mem_req_t pend[$];
   exp_t     sb[$];

   int    checks = 0;
   int    failures = 0;
   int    epoch = 0;
   int    cyc = 0;
   int    pops = 0;
   int    grants = 0;
   addr_t next_pc = RST_PC;
   logic  rst_prev = 1'b1;

   int unsigned p_gnt = 100;
   int unsigned p_rdy = 100;
   int unsigned p_rsp = 100;
   int unsigned max_lat = 1;
   logic        do_reset = 1'b1;
   logic        do_redirect = 1'b0;
   addr_t       redirect_target = '0;

   function automatic word_t mem_word(input addr_t a);
      return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, then check and update the model.
   task automatic step();
      logic     req_exp;
      mem_req_t m;
      @(negedge clk);
      cyc++;
      rst_i         = do_reset;
      redirect_i    = do_redirect && !do_reset;
      redirect_pc_i = redirect_target;
      imem_gnt_i    = ($urandom_range(99) < p_gnt);
      instr_ready_i = ($urandom_range(99) < p_rdy);
      imem_rvalid_i = !do_reset && (pend.size() > 0) && (pend[0].due <= cyc) &&
                      ($urandom_range(99) < p_rsp);
      imem_rdata_i  = imem_rvalid_i ? mem_word(pend[0].dut_addr) : word_t'($urandom);
      #1;
      assert (!imem_rvalid_i || pend.size() != 0)
         else $error("memory model responded with nothing outstanding");
      check("instr_valid", 32'(instr_valid_o), 32'(sb.size() != 0));
      req_exp = !rst_i && !rst_prev && !redirect_i && ((pend.size() + sb.size()) < DEPTH);
      check("imem_req", 32'(imem_req_o), 32'(req_exp));
      if (rst_i) begin
         pend.delete();
         sb.delete();
         epoch++;
         next_pc = RST_PC;
      end else begin
         if (imem_rvalid_i) begin
            m = pend.pop_front();
            if (!redirect_i && m.ep == epoch) begin
               check("buffer_room", 32'(sb.size() < DEPTH), 32'd1);
               sb.push_back('{pc: m.exp_pc, instr: mem_word(m.exp_pc)});
            end
         end
         if (imem_req_o && imem_gnt_i) begin
            check("fetch_addr", imem_addr_o, next_pc);
            pend.push_back('{dut_addr: imem_addr_o, exp_pc: next_pc, ep: epoch,
                             due: cyc + int'($urandom_range(max_lat, 1))});
            next_pc = next_pc + 32'd4;
            grants++;
         end
         if (redirect_i) begin
            sb.delete();
            epoch++;
            next_pc = redirect_pc_i & ~32'h3;
         end
      end
      rst_prev    = rst_i;
      do_redirect = 1'b0;
   endtask

   task automatic pulse_reset(input int n);
      do_reset = 1'b1;
      repeat (n) step();
      do_reset = 1'b0;
   endtask

   task automatic set_knobs(input int unsigned g, input int unsigned r,
                            input int unsigned s, input int unsigned l);
      p_gnt = g; p_rdy = r; p_rsp = s; max_lat = l;
   endtask

   // Monitor: every handshake pops the oldest expected instruction and compares it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (instr_valid_o && instr_ready_i && !redirect_i && !rst_i) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_instr: got pc %h instr %h, expected none (cycle %0d)",
                        instr_pc_o, instr_o, cyc);
            end else begin
               e = sb.pop_front();
               check("instr_pc", instr_pc_o, e.pc);
               check("instr_word", instr_o, e.instr);
               pops++;
            end
         end
      end
   end

   initial begin
      int g0;
      int p0;

      // Streaming from a reset PC that wraps: FFF8, FFFC, 0000, ... one per cycle.
      set_knobs(100, 100, 100, 1);
      pulse_reset(3);
      g0 = grants; p0 = pops;
      repeat (20) step();
      #2;
      check("stream_grants", 32'(grants - g0), 32'd19);
      check("stream_pops", 32'(pops - p0), 32'd17);

      // Decoder stalled: exactly DEPTH grants, then all of them drain in order.
      pulse_reset(1);
      set_knobs(100, 0, 100, 1);
      g0 = grants;
      repeat (12) step();
      check("stall_grants", 32'(grants - g0), 32'(DEPTH));
      set_knobs(0, 100, 100, 1);
      p0 = pops;
      repeat (10) step();
      #2;
      check("drain_pops", 32'(pops - p0), 32'(DEPTH));

      // Three requests in flight, then redirect to 0x100: late responses must vanish.
      pulse_reset(1);
      set_knobs(100, 100, 0, 1);
      repeat (4) step();
      check("inflight", 32'(pend.size()), 32'd3);
      redirect_target = 32'h0000_0100;
      do_redirect = 1'b1;
      step();
      set_knobs(100, 100, 100, 1);
      repeat (12) step();

      // Redirect to an unaligned target with a response landing in the same cycle.
      redirect_target = 32'h0000_0203;
      do_redirect = 1'b1;
      step();
      repeat (10) step();

      // Reset with words buffered and requests outstanding.
      set_knobs(100, 0, 100, 1);
      pulse_reset(1);
      repeat (4) step();
      set_knobs(100, 0, 0, 1);
      step();
      check("pre_reset_outstanding", 32'(pend.size()), 32'd2);
      check("pre_reset_buffered", 32'(sb.size()), 32'd2);
      pulse_reset(1);
      set_knobs(100, 100, 100, 1);
      repeat (10) step();

      // Randomised operation with occasional redirects and resets.
      for (int blk = 0; blk < 40; blk++) begin
         set_knobs($urandom_range(100, 20), $urandom_range(100, 10),
                   $urandom_range(100, 20), $urandom_range(4, 1));
         for (int i = 0; i < 100; i++) begin
            if ($urandom_range(99) < 4) begin
               redirect_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                          : 32'($urandom);
               do_redirect = 1'b1;
            end
            do_reset = ($urandom_range(999) < 3);
            step();
         end
         do_reset = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
